// File: rtl/ls374_bus_reader.sv
// rtl/ls374_bus_reader.sv - reads one of NSRC octal 3-state registers sharing a bus
// One enable at a time, a settle interval before sampling, and a turnaround cycle after every read.
module ls374_bus_reader #(
  parameter int WIDTH  = 8,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  output logic [NSRC-1:0]  oe_n,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] rd_data,
  output logic [SEL_W-1:0] rd_src,
  output logic             rd_err,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, ENABLE, HOLD, TURN} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NSRC-1:0]    oe_n_q, oe_n_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [SEL_W-1:0]   rd_src_q, rd_src_d;
  logic               rd_err_q, rd_err_d;
  logic               rd_valid_q, rd_valid_d;

  logic               sel_ok;
  logic [NSRC-1:0]    oe_req;

  // Select range check is widened by one bit so NSRC == 2**SEL_W compares correctly.
  always_comb begin
    sel_ok = ({1'b0, req_sel} < (SEL_W+1)'(NSRC));
    oe_req = '1;
    for (int i = 0; i < NSRC; i++) begin
      oe_req[i] = (SEL_W'(i) != req_sel);
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    oe_n_d     = oe_n_q;
    rd_data_d  = rd_data_q;
    rd_src_d   = rd_src_q;
    rd_err_d   = rd_err_q;
    rd_valid_d = rd_valid_q;
    case (state_q)
      IDLE: begin
        oe_n_d = '1;
        if (req) begin
          if (sel_ok) begin
            sel_d   = req_sel;
            cnt_d   = CNT_W'(SETTLE - 1);
            oe_n_d  = oe_req;
            state_d = ENABLE;
          end else begin
            rd_data_d  = '1;
            rd_src_d   = req_sel;
            rd_err_d   = 1'b1;
            rd_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end
      end
      ENABLE: begin
        if (cnt_q == '0) begin
          rd_data_d  = bus_in;
          rd_src_d   = sel_q;
          rd_err_d   = 1'b0;
          rd_valid_d = 1'b1;
          oe_n_d     = '1;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        oe_n_d = '1;
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = TURN;
        end
      end
      TURN: begin
        oe_n_d  = '1;
        state_d = IDLE;
      end
      default: begin
        oe_n_d  = '1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      oe_n_q     <= '1;
      rd_data_q  <= '0;
      rd_src_q   <= '0;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      oe_n_q     <= oe_n_d;
      rd_data_q  <= rd_data_d;
      rd_src_q   <= rd_src_d;
      rd_err_q   <= rd_err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign oe_n      = oe_n_q;
  assign rd_data   = rd_data_q;
  assign rd_src    = rd_src_q;
  assign rd_err    = rd_err_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_ls374_bus_reader.sv
// tb/tb_ls374_bus_reader.sv - randomized self-checking bench for ls374_bus_reader
// Instance 0 has four sources, instance 1 has three so select 3 names a missing register.
module tb_ls374_bus_reader;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req       [2];
  logic [1:0] req_sel   [2];
  logic [7:0] bus_in    [2];
  logic       rd_ready  [2];
  logic       req_ready [2];
  logic [7:0] rd_data   [2];
  logic [1:0] rd_src    [2];
  logic       rd_err    [2];
  logic       rd_valid  [2];
  logic [3:0] oe_n0;
  logic [2:0] oe_n1;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en   = 1'b0;

  always #5 clk = ~clk;

  ls374_bus_reader #(.WIDTH(8), .NSRC(4), .SEL_W(2), .SETTLE(SETTLE)) u_dut4 (
    .clk(clk), .rst(rst), .req(req[0]), .req_sel(req_sel[0]), .req_ready(req_ready[0]),
    .oe_n(oe_n0), .bus_in(bus_in[0]), .rd_data(rd_data[0]), .rd_src(rd_src[0]),
    .rd_err(rd_err[0]), .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0])
  );

  ls374_bus_reader #(.WIDTH(8), .NSRC(3), .SEL_W(2), .SETTLE(SETTLE)) u_dut3 (
    .clk(clk), .rst(rst), .req(req[1]), .req_sel(req_sel[1]), .req_ready(req_ready[1]),
    .oe_n(oe_n1), .bus_in(bus_in[1]), .rd_data(rd_data[1]), .rd_src(rd_src[1]),
    .rd_err(rd_err[1]), .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] oe_of(input int d);
    return (d == 0) ? oe_n0 : {1'b1, oe_n1};
  endfunction

  function automatic int nsrc_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus is wrong until the last enabled cycle, so a sample on any other edge is caught.
  task automatic do_read(input int d, input logic [1:0] sel, input logic [7:0] data,
                         input int nwait, input bit hold_req);
    bit         ok;
    bit         acc;
    bit         valid_sel;
    logic [3:0] exp_oe;
    logic [7:0] exp_data;
    ok        = 1'b0;
    valid_sel = (int'(sel) < nsrc_of(d));
    exp_oe    = 4'hF & ~(4'h1 << sel);
    exp_data  = valid_sel ? data : 8'hFF;
    req[d]      = 1'b1;
    req_sel[d]  = sel;
    bus_in[d]   = (SETTLE > 1) ? ~data : data;
    rd_ready[d] = (nwait == 0);
    for (int i = 0; i < 20; i++) begin
      acc = req_ready[d];
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      req[d] = 1'b0;
      return;
    end
    if (!hold_req) req[d] = 1'b0;
    req_sel[d] = 2'($urandom);
    if (valid_sel) begin
      for (int k = 0; k < SETTLE; k++) begin
        check("oe_enable", oe_of(d), exp_oe);
        check("valid_early", rd_valid[d], 1'b0);
        check("ready_busy", req_ready[d], 1'b0);
        if (k == SETTLE - 1) bus_in[d] = data;
        step();
      end
    end
    check("rd_valid", rd_valid[d], 1'b1);
    check("rd_data", rd_data[d], exp_data);
    check("rd_src", rd_src[d], sel);
    check("rd_err", rd_err[d], !valid_sel);
    check("oe_hold", oe_of(d), 4'hF);
    for (int i = 0; i < nwait; i++) begin
      bus_in[d] = 8'($urandom);
      step();
      check("bp_valid", rd_valid[d], 1'b1);
      check("bp_data", rd_data[d], exp_data);
      check("bp_src", rd_src[d], sel);
      check("bp_oe", oe_of(d), 4'hF);
    end
    rd_ready[d] = 1'b1;
    step();
    check("turn_valid", rd_valid[d], 1'b0);
    check("turn_ready", req_ready[d], 1'b0);
    check("turn_oe", oe_of(d), 4'hF);
    step();
    check("idle_ready", req_ready[d], 1'b1);
    check("idle_oe", oe_of(d), 4'hF);
  endtask

  task automatic reset_mid_read(input logic [1:0] sel, input int depth);
    bit ok;
    bit acc;
    ok          = 1'b0;
    req[1]      = 1'b0;
    req[0]      = 1'b1;
    req_sel[0]  = sel;
    rd_ready[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      acc = req_ready[0];
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    req[0] = 1'b0;
    if (!ok) begin
      check("rst_accept_timeout", 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < depth; k++) step();
    check("rst_pre_oe", oe_of(0), 4'hF & ~(4'h1 << sel));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_oe", oe_of(0), 4'hF);
    check("rst_valid", rd_valid[0], 1'b0);
    check("rst_ready", req_ready[0], 1'b1);
    check("rst_data", rd_data[0], 8'h00);
    for (int k = 0; k < SETTLE + 2; k++) begin
      step();
      check("rst_no_valid", rd_valid[0], 1'b0);
    end
  endtask

  // Bus contention rule: never more than one enable low.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        check("one_enable", ($countones(~oe_of(d)) <= 1), 1'b1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         d;
    logic [1:0] s;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b1; req_sel[i] = 2'd0; bus_in[i] = 8'h00; rd_ready[i] = 1'b1;
    end
    step();
    step();
    check("rst_hold_oe", oe_of(0), 4'hF);
    check("rst_hold_valid", rd_valid[0], 1'b0);
    rst = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("reset_oe", oe_of(i), 4'hF);
      check("reset_valid", rd_valid[i], 1'b0);
      check("reset_ready", req_ready[i], 1'b1);
      check("reset_data", rd_data[i], 8'h00);
      check("reset_src", rd_src[i], 2'd0);
      check("reset_err", rd_err[i], 1'b0);
    end
    mon_en = 1'b1;
    step();

    do_read(0, 2'd2, 8'hAA, 0, 1'b0);
    do_read(0, 2'd0, 8'h55, 5, 1'b0);
    do_read(0, 2'd1, 8'h12, 0, 1'b1);
    do_read(0, 2'd3, 8'h34, 0, 1'b1);
    req[0] = 1'b0;
    do_read(1, 2'd3, 8'h77, 0, 1'b0);
    do_read(1, 2'd2, 8'h3C, 2, 1'b0);
    reset_mid_read(2'd0, 0);
    do_read(0, 2'd0, 8'hC3, 0, 1'b0);

    for (int it = 0; it < 60; it++) begin
      d = $urandom_range(0, 1);
      s = 2'($urandom_range(0, 3));
      req[1 - d] = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        reset_mid_read(s, $urandom_range(0, SETTLE - 1));
      end else begin
        do_read(d, s, 8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
